// File: rtl/c1541_pkg.sv
// Shared constants and types for the 1541 track loader and the GCR stage.
package c1541_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } loader_state_e;

  localparam logic [5:0] MAX_TRACK   = 6'd34;

  // First track of zones 1..3; zone 0 starts at track 0.
  localparam logic [5:0] ZONE1_TRACK = 6'd17;
  localparam logic [5:0] ZONE2_TRACK = 6'd24;
  localparam logic [5:0] ZONE3_TRACK = 6'd30;

  localparam logic [9:0] ZONE1_BASE  = 10'd357;
  localparam logic [9:0] ZONE2_BASE  = 10'd490;
  localparam logic [9:0] ZONE3_BASE  = 10'd598;

  localparam logic [9:0] SPT_Z0      = 10'd21;
  localparam logic [9:0] SPT_Z1      = 10'd19;
  localparam logic [9:0] SPT_Z2      = 10'd18;
  localparam logic [9:0] SPT_Z3      = 10'd17;

endpackage

// File: rtl/c1541_track_lba.sv
// Combinational D64 track -> first-sector LBA mapping (256-byte units).
module c1541_track_lba
  import c1541_pkg::*;
(
  input  logic [5:0] track,
  output logic [9:0] lba
);

  logic [9:0] t;

  always_comb begin
    t   = (track > MAX_TRACK) ? {4'b0, MAX_TRACK} : {4'b0, track};
    lba = '0;
    if (t < {4'b0, ZONE1_TRACK})
      lba = t * SPT_Z0;
    else if (t < {4'b0, ZONE2_TRACK})
      lba = ZONE1_BASE + (t - {4'b0, ZONE1_TRACK}) * SPT_Z1;
    else if (t < {4'b0, ZONE3_TRACK})
      lba = ZONE2_BASE + (t - {4'b0, ZONE2_TRACK}) * SPT_Z2;
    else
      lba = ZONE3_BASE + (t - {4'b0, ZONE3_TRACK}) * SPT_Z3;
  end

endmodule

// File: rtl/c1541_track_loader.sv
// Track-buffer sequencer: debounces head steps, writes back dirty tracks and
// loads the current track from the SD image over the sd_rd/sd_wr/sd_ack handshake.
//
// state      | meaning
// IDLE       | buffer idle; watch for first load, head step or flush
// SETTLE     | head moved; wait for track to hold still for SETTLE cycles
// WR_REQ     | write request for loaded_track raised, waiting for ack
// WR_WAIT    | write-back in progress, waiting for ack to drop
// RD_REQ     | read request for target raised, waiting for ack
// RD_WAIT    | read in progress, waiting for ack to drop
module c1541_track_loader
  import c1541_pkg::*;
#(
  parameter logic [19:0] SETTLE = 20'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        disk_ready,
  input  logic        img_readonly,
  input  logic        mtr,
  input  logic [5:0]  track,
  input  logic        we,
  output logic        busy,
  output logic [5:0]  loaded_track,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack
);

  loader_state_e state, state_nxt;
  logic [5:0]    track_c;
  logic [5:0]    target, target_nxt;
  logic [5:0]    loaded_nxt;
  logic [19:0]   cnt, cnt_nxt;
  logic          valid, valid_nxt;
  logic          dirty, dirty_nxt;
  logic          mount_seen, mount_nxt;
  logic [5:0]    lba_track;
  logic [9:0]    lba;

  assign track_c   = (track > MAX_TRACK) ? MAX_TRACK : track;
  assign lba_track = (state == ST_WR_REQ) ? loaded_track : target;

  c1541_track_lba u_lba (
    .track (lba_track),
    .lba   (lba)
  );

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    loaded_nxt = loaded_track;
    cnt_nxt    = cnt;
    valid_nxt  = valid;
    dirty_nxt  = dirty;
    mount_nxt  = mount_seen;

    // A write in the same cycle IDLE is left must still reach the write-back.
    if (we && state == ST_IDLE) dirty_nxt = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (disk_ready) begin
          if (!valid) begin
            state_nxt  = ST_RD_REQ;
            target_nxt = track_c;
          end else if (track_c != loaded_track) begin
            state_nxt  = ST_SETTLE;
            target_nxt = track_c;
            cnt_nxt    = SETTLE - 20'd1;
          end else if (!mtr && dirty && !img_readonly) begin
            state_nxt  = ST_WR_REQ;
          end
        end
      end
      ST_SETTLE: begin
        if (!disk_ready || !valid || track_c == loaded_track) begin
          state_nxt = ST_IDLE;
        end else if (track_c != target) begin
          target_nxt = track_c;
          cnt_nxt    = SETTLE - 20'd1;
        end else if (cnt == '0) begin
          state_nxt = (dirty && !img_readonly) ? ST_WR_REQ : ST_RD_REQ;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
      end
      ST_WR_REQ: begin
        if (sd_ack) state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!sd_ack) begin
          dirty_nxt = 1'b0;
          if (disk_ready && track_c != loaded_track) begin
            state_nxt  = ST_RD_REQ;
            target_nxt = track_c;
          end else begin
            state_nxt  = ST_IDLE;
          end
        end
      end
      ST_RD_REQ: begin
        if (img_mounted) mount_nxt = 1'b1;
        if (sd_ack) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (sd_ack) begin
          if (img_mounted) mount_nxt = 1'b1;
        end else begin
          // A mount during the read leaves data from the old image: keep invalid.
          loaded_nxt = target;
          valid_nxt  = !(mount_seen || img_mounted);
          dirty_nxt  = 1'b0;
          mount_nxt  = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (img_mounted) begin
      valid_nxt = 1'b0;
      dirty_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      target       <= '0;
      loaded_track <= 6'h3F;
      cnt          <= '0;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      mount_seen   <= 1'b0;
      busy         <= 1'b1;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_lba       <= '0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      loaded_track <= loaded_nxt;
      cnt          <= cnt_nxt;
      valid        <= valid_nxt;
      dirty        <= dirty_nxt;
      mount_seen   <= mount_nxt;
      busy         <= !valid || !disk_ready || (state != ST_IDLE);
      sd_rd        <= (state == ST_RD_REQ) && !sd_ack;
      sd_wr        <= (state == ST_WR_REQ) && !sd_ack;
      if (state == ST_RD_REQ || state == ST_WR_REQ)
        sd_lba <= {22'b0, lba};
    end
  end

endmodule

// File: tb/tb_c1541_track_loader.sv
// Scenario bench for c1541_track_loader with an auto-acking SD host model.
module tb_c1541_track_loader;

  logic        clk = 1'b0;
  logic        reset, img_mounted, disk_ready, img_readonly, mtr, we, sd_ack;
  logic [5:0]  track;
  logic        busy, sd_rd, sd_wr;
  logic [5:0]  loaded_track;
  logic [31:0] sd_lba;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] lba;
    logic        stable;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  xfer_t host_x;

  c1541_track_loader #(.SETTLE(20'd8)) dut (
    .clk          (clk),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .disk_ready   (disk_ready),
    .img_readonly (img_readonly),
    .mtr          (mtr),
    .track        (track),
    .we           (we),
    .busy         (busy),
    .loaded_track (loaded_track),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack)
  );

  always #5 clk = ~clk;

  // Independent model: LBA is the running sum of sectors on earlier tracks.
  function automatic logic [31:0] lba_model(int t);
    int s = 0;
    for (int i = 0; i < t; i++)
      s += (i < 17) ? 21 : (i < 24) ? 19 : (i < 30) ? 18 : 17;
    return 32'(s);
  endfunction

  // SD host: acknowledges any request for 5 cycles and records what it saw.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && (sd_rd || sd_wr)) begin
        host_x.wr     = sd_wr;
        host_x.lba    = sd_lba;
        host_x.stable = 1'b1;
        @(negedge clk);
        sd_ack = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (sd_lba !== host_x.lba || sd_rd || sd_wr) host_x.stable = 1'b0;
        end
        sd_ack = 1'b0;
        obs_q.push_back(host_x);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; img_mounted = 1'b0; disk_ready = 1'b1; img_readonly = 1'b0;
    mtr = 1'b1; we = 1'b0; track = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL reset_sd_rd got %b want 0", sd_rd); end
    checks++; if (sd_wr !== 1'b0) begin errors++; $display("FAIL reset_sd_wr got %b want 0", sd_wr); end
    checks++; if (sd_lba !== 32'd0) begin errors++; $display("FAIL reset_sd_lba got %0d want 0", sd_lba); end
    checks++; if (loaded_track !== 6'h3F) begin errors++; $display("FAIL reset_loaded got %h want 3f", loaded_track); end
  endtask

  task automatic test_first_load();
    xfer_t e, o;
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(xfer_t'{1'b0, lba_model(0), 1'b1});
    @(posedge clk); #1;
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL first_rd_early got %b want 0", sd_rd); end
    @(posedge clk); #1;
    checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL first_rd_rise got %b want 1", sd_rd); end
    repeat (25) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL first_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL first_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy got %b want 0", busy); end
    checks++; if (loaded_track !== 6'd0) begin errors++; $display("FAIL first_loaded got %0d want 0", loaded_track); end
  endtask

  task automatic test_step();
    xfer_t e, o;
    @(negedge clk); track = 6'd18;
    exp_q.push_back(xfer_t'{1'b0, lba_model(18), 1'b1});
    repeat (9) @(posedge clk); #1;
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL step_rd_early got %b want 0", sd_rd); end
    @(posedge clk); #1;
    checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL step_rd_rise got %b want 1", sd_rd); end
    repeat (25) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL step_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL step_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd18) begin errors++; $display("FAIL step_loaded got %0d want 18", loaded_track); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_busy got %b want 0", busy); end
  endtask

  task automatic test_dirty_step();
    xfer_t e, o;
    @(negedge clk); we = 1'b1;
    @(negedge clk); we = 1'b0; track = 6'd34;
    exp_q.push_back(xfer_t'{1'b1, lba_model(18), 1'b1});
    exp_q.push_back(xfer_t'{1'b0, lba_model(34), 1'b1});
    repeat (60) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL dirty_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL dirty_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd34) begin errors++; $display("FAIL dirty_loaded got %0d want 34", loaded_track); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dirty_busy got %b want 0", busy); end
  endtask

  task automatic test_bounce();
    xfer_t e, o;
    @(negedge clk); track = 6'd5;
    exp_q.push_back(xfer_t'{1'b0, lba_model(5), 1'b1});
    repeat (35) @(posedge clk);
    @(negedge clk); track = 6'd6;
    repeat (3) @(negedge clk);
    track = 6'd5;
    repeat (30) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bounce_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL bounce_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd5) begin errors++; $display("FAIL bounce_loaded got %0d want 5", loaded_track); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b want 0", busy); end
  endtask

  task automatic test_flush();
    xfer_t e, o;
    @(negedge clk); we = 1'b1;
    @(negedge clk); we = 1'b0; mtr = 1'b0;
    exp_q.push_back(xfer_t'{1'b1, lba_model(5), 1'b1});
    repeat (30) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL flush_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (loaded_track !== 6'd5) begin errors++; $display("FAIL flush_loaded got %0d want 5", loaded_track); end
    mtr = 1'b1;
  endtask

  task automatic test_mount_readonly();
    xfer_t e, o;
    @(negedge clk); we = 1'b1; img_readonly = 1'b1;
    @(negedge clk); we = 1'b0; track = 6'd7;
    exp_q.push_back(xfer_t'{1'b0, lba_model(7), 1'b1});
    exp_q.push_back(xfer_t'{1'b0, lba_model(7), 1'b1});
    for (int i = 0; i < 40 && sd_ack !== 1'b1; i++) @(negedge clk);
    checks++; if (sd_ack !== 1'b1) begin errors++; $display("FAIL mount_wait_ack got %b want 1", sd_ack); end
    @(negedge clk); img_mounted = 1'b1;
    @(negedge clk); img_mounted = 1'b0;
    repeat (40) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mount_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL mount_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd7) begin errors++; $display("FAIL mount_loaded got %0d want 7", loaded_track); end
    // The mount discarded the dirty flag: no flush once writable and motor off.
    @(negedge clk); img_readonly = 1'b0; mtr = 1'b0;
    repeat (25) @(posedge clk); #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mount_no_flush got %0d want 0", obs_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mount_busy got %b want 0", busy); end
    obs_q.delete();
    mtr = 1'b1;
  endtask

  task automatic test_not_ready();
    xfer_t e, o;
    @(negedge clk); disk_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nr_busy got %b want 1", busy); end
    @(negedge clk); track = 6'd20;
    repeat (30) @(posedge clk); #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL nr_no_xfer got %0d want 0", obs_q.size()); end
    obs_q.delete();
    @(negedge clk); disk_ready = 1'b1;
    exp_q.push_back(xfer_t'{1'b0, lba_model(20), 1'b1});
    repeat (35) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL nr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL nr_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd20) begin errors++; $display("FAIL nr_loaded got %0d want 20", loaded_track); end
  endtask

  task automatic test_clamp();
    xfer_t e, o;
    @(negedge clk); track = 6'd50;
    exp_q.push_back(xfer_t'{1'b0, lba_model(34), 1'b1});
    repeat (35) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.lba !== e.lba || o.stable !== 1'b1) begin errors++; $display("FAIL clamp_xfer got wr=%b lba=%0d st=%b want wr=%b lba=%0d", o.wr, o.lba, o.stable, e.wr, e.lba); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (loaded_track !== 6'd34) begin errors++; $display("FAIL clamp_loaded got %0d want 34", loaded_track); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_step();
    test_dirty_step();
    test_bounce();
    test_flush();
    test_mount_readonly();
    test_not_ready();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
